// File: rtl/uart_byte_bridge_pkg.sv
// uart_byte_bridge_pkg
// Shared definitions for the UART byte bridge: TX state encodings and the
// default FIFO geometry used by uart_byte_bridge and byte_fifo.
package uart_byte_bridge_pkg;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_byte_bridge_fifo.sv
// byte_fifo
// Synchronous byte FIFO with first-word fall-through output.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (flushes pointers/count)
//   push, din       : write din at the tail; ignored when full unless pop
//                     frees the slot in the same cycle
//   pop             : drop the head; ignored when empty
//   dout            : current head, reads 0 while empty
//   full, empty     : count==DEPTH / count==0
//   count           : number of stored entries (ADDR_WIDTH+1 bits)
// Callers that must not accept a write while full (TX side) qualify push
// themselves before it reaches this module.
module byte_fifo
    import uart_byte_bridge_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic                full,
    output logic                empty,
    output logic [ADDR_WIDTH:0] count
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, wr_ptr==rd_ptr, so a write alongside a pop lands in the slot
    // the head is vacating and becomes the new tail.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only observed through dout, which is
    // forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/uart_byte_bridge.sv
// uart_byte_bridge
// Byte buffering bridge between user logic and the uart serial core.
// A TX FIFO feeds the core one byte per transmit pulse; an RX FIFO captures
// every received pulse, with sticky overflow and framing-error flags.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   wr_en, wr_data, tx_full    : user TX push side
//   tx_empty                   : TX FIFO empty and no byte in flight
//   rd_en, rd_data, rx_empty   : user RX pop side (first-word fall-through)
//   rx_overflow, rx_frame_err  : sticky flags, cleared by clr_flags
//   uart_transmit, uart_tx_byte: one-cycle launch pulse and held byte to core
//   uart_is_transmitting       : core busy level
//   uart_received, uart_rx_byte, uart_rx_error : core receive side
//   rx_drop_count              : saturating dropped-byte counter (only with
//                                UART_BRIDGE_OVERFLOW_CNT_EN defined)
//   tx_state, tx_count, rx_count : debug view of the TX FSM and FIFO levels
// Handshakes: a user write is taken on any clk edge with wr_en=1 and
// tx_full=0 (otherwise dropped); a user read is taken on any edge with
// rd_en=1 and rx_empty=0 (otherwise ignored). A core receive pulse is never
// back-pressured: it is stored, or dropped and counted as overflow.
module uart_byte_bridge
    import uart_byte_bridge_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    output logic                tx_full,
    output logic                tx_empty,
    input  logic                rd_en,
    output logic [7:0]          rd_data,
    output logic                rx_empty,
    output logic                rx_overflow,
    output logic                rx_frame_err,
    input  logic                clr_flags,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_is_transmitting,
    input  logic                uart_received,
    input  logic [7:0]          uart_rx_byte,
    input  logic                uart_rx_error,
`ifdef UART_BRIDGE_OVERFLOW_CNT_EN
    output logic [7:0]          rx_drop_count,
`endif
    output logic [1:0]          tx_state,
    output logic [ADDR_WIDTH:0] tx_count,
    output logic [ADDR_WIDTH:0] rx_count
);

    tx_state_t  state_q;
    tx_state_t  state_d;
    logic       launch;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
    logic [7:0] tx_head;
    logic       tx_push;
    logic       rx_fifo_full;
    logic       rx_pop;
    logic       rx_drop;

    // TX FIFO: fullness is judged before the edge, so a write arriving while
    // full is lost even if the FSM pops in the same cycle.
    assign tx_push = wr_en && !tx_fifo_full;

    byte_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (launch),
        .din   (wr_data),
        .dout  (tx_head),
        .full  (tx_fifo_full),
        .empty (tx_fifo_empty),
        .count (tx_count)
    );

    // RX FIFO: a receive while full still succeeds when the user reads in
    // the same cycle; otherwise the byte is dropped.
    assign rx_pop  = rd_en && !rx_empty;
    assign rx_drop = uart_received && rx_fifo_full && !rx_pop;

    byte_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_received),
        .pop   (rx_pop),
        .din   (uart_rx_byte),
        .dout  (rd_data),
        .full  (rx_fifo_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX launch FSM. The core raises its busy flag a cycle after the pulse,
    // so we wait to see busy go high before waiting for it to drop; this
    // prevents a second launch inside that lag.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    launch  = 1'b1;
                    state_d = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (uart_is_transmitting) state_d = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (!uart_is_transmitting) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= TX_IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            state_q       <= state_d;
            uart_transmit <= launch;
            if (launch) uart_tx_byte <= tx_head;
        end
    end

    assign tx_state = state_q;
    assign tx_full  = tx_fifo_full;
    assign tx_empty = tx_fifo_empty && (state_q == TX_IDLE);

    // Sticky flags: a set in the same cycle as clr_flags wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_overflow  <= rx_drop       || (rx_overflow  && !clr_flags);
            rx_frame_err <= uart_rx_error || (rx_frame_err && !clr_flags);
        end
    end

`ifdef UART_BRIDGE_OVERFLOW_CNT_EN
    // Drop counter follows the flag rule: a drop alongside clr_flags
    // restarts the count at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_drop_count <= 8'h00;
        end else if (clr_flags) begin
            rx_drop_count <= rx_drop ? 8'h01 : 8'h00;
        end else if (rx_drop && (rx_drop_count != 8'hFF)) begin
            rx_drop_count <= rx_drop_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_uart_byte_bridge.sv
module tb_uart_byte_bridge;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_full, tx_empty;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty, rx_overflow, rx_frame_err;
  logic       clr_flags = 1'b0;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting;
  logic       uart_received = 1'b0;
  logic [7:0] uart_rx_byte = 8'h00;
  logic       uart_rx_error = 1'b0;
  logic [1:0] tx_state;
  logic [4:0] tx_count, rx_count;
`ifdef UART_BRIDGE_OVERFLOW_CNT_EN
  logic [7:0] rx_drop_count;
`endif

  uart_byte_bridge dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .tx_full              (tx_full),
    .tx_empty             (tx_empty),
    .rd_en                (rd_en),
    .rd_data              (rd_data),
    .rx_empty             (rx_empty),
    .rx_overflow          (rx_overflow),
    .rx_frame_err         (rx_frame_err),
    .clr_flags            (clr_flags),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .uart_received        (uart_received),
    .uart_rx_byte         (uart_rx_byte),
    .uart_rx_error        (uart_rx_error),
`ifdef UART_BRIDGE_OVERFLOW_CNT_EN
    .rx_drop_count        (rx_drop_count),
`endif
    .tx_state             (tx_state),
    .tx_count             (tx_count),
    .rx_count             (rx_count)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- counters and check helper ----------------
  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- uart core model (environment) ----------------
  // Busy rises one cycle after the launch pulse is seen and lasts busy_len
  // cycles; core_hold forces busy high indefinitely.
  int  busy_len = 10;
  bit  core_hold = 1'b0;
  int  remain = 0;
  bit  start_pending = 1'b0;
  bit  cnt_busy = 1'b0;
  logic [7:0] launch_log[$];
  int         launch_cyc[$];

  assign uart_is_transmitting = core_hold | cnt_busy;

  always @(negedge clk) begin
    if (start_pending) begin
      remain = busy_len;
      start_pending = 1'b0;
    end else if (remain > 0) begin
      remain--;
    end
    cnt_busy = (remain > 0);
    if (uart_transmit === 1'b1) begin
      start_pending = 1'b1;
      launch_log.push_back(uart_tx_byte);
      launch_cyc.push_back(cyc);
    end
  end

  // ---------------- behavioural reference model ----------------
  // Transaction-level view: a queue per direction, a flag for "a byte is
  // owned by the core" (cleared once the core has been seen busy and then
  // idle), and the sticky flags.
  logic [7:0] m_tx_q[$];
  logic [7:0] m_rx_q[$];
  bit         m_owned, m_seen_busy, m_launch, m_ovf, m_ferr;
  logic [7:0] m_byte;
  int         m_drops;
  bit         t_tx_ok, t_launch, t_rd, t_acc, t_drop;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_owned = 0; m_seen_busy = 0; m_launch = 0;
      m_ovf = 0; m_ferr = 0; m_byte = 8'h00; m_drops = 0;
    end else begin
      t_tx_ok  = wr_en && (m_tx_q.size() < DEPTH);
      t_launch = !m_owned && (m_tx_q.size() > 0);
      if (m_owned) begin
        if (!m_seen_busy) begin
          if (uart_is_transmitting) m_seen_busy = 1;
        end else if (!uart_is_transmitting) begin
          m_owned = 0;
          m_seen_busy = 0;
        end
      end
      if (t_launch) begin
        m_byte = m_tx_q.pop_front();
        m_owned = 1;
        m_seen_busy = 0;
      end
      m_launch = t_launch;
      if (t_tx_ok) m_tx_q.push_back(wr_data);

      t_rd   = rd_en && (m_rx_q.size() > 0);
      t_acc  = uart_received && ((m_rx_q.size() < DEPTH) || t_rd);
      t_drop = uart_received && !t_acc;
      if (t_rd) void'(m_rx_q.pop_front());
      if (t_acc) m_rx_q.push_back(uart_rx_byte);
      m_ovf  = t_drop || (m_ovf && !clr_flags);
      m_ferr = uart_rx_error || (m_ferr && !clr_flags);
      if (clr_flags) m_drops = t_drop ? 1 : 0;
      else if (t_drop && m_drops < 255) m_drops++;
    end
  end

  // ---------------- per-cycle compare (scoreboard) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_full", tx_full, m_tx_q.size() == DEPTH);
      chk("tx_empty", tx_empty, (m_tx_q.size() == 0) && !m_owned);
      chk("uart_transmit", uart_transmit, m_launch);
      chk("uart_tx_byte", uart_tx_byte, m_byte);
      chk("rx_empty", rx_empty, m_rx_q.size() == 0);
      chk("rd_data", rd_data, (m_rx_q.size() > 0) ? m_rx_q[0] : 8'h00);
      chk("rx_overflow", rx_overflow, m_ovf);
      chk("rx_frame_err", rx_frame_err, m_ferr);
      chk("rx_count", rx_count, m_rx_q.size());
`ifdef UART_BRIDGE_OVERFLOW_CNT_EN
      chk("rx_drop_count", rx_drop_count, m_drops);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; uart_received = 1'b0;
    uart_rx_error = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!tx_empty && n < budget) begin
      tick();
      n++;
    end
    chk("tx_drain_in_budget", tx_empty, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_uart_transmit"}, uart_transmit, 1'b0);
    chk({tag, "_uart_tx_byte"}, uart_tx_byte, 8'h00);
    chk({tag, "_tx_full"}, tx_full, 1'b0);
    chk({tag, "_tx_empty"}, tx_empty, 1'b1);
    chk({tag, "_rx_empty"}, rx_empty, 1'b1);
    chk({tag, "_rx_overflow"}, rx_overflow, 1'b0);
    chk({tag, "_rx_frame_err"}, rx_frame_err, 1'b0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
    chk({tag, "_tx_state"}, tx_state, 2'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w_cyc, gap, n, base;
    logic [7:0] exp_b;

    rst_n = 1'b0;
    tick(); tick(); tick();
    check_reset_values("reset");
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Two back-to-back writes, 10-cycle busy per byte.
    busy_len = 10;
    launch_log.delete(); launch_cyc.delete();
    tick(); wr_en = 1'b1; wr_data = 8'h55;
    tick(); wr_en = 1'b1; wr_data = 8'hA3;
    w_cyc = cyc;
    wait_drain(200);
    repeat (3) tick();
    chk("two_launches", launch_log.size(), 2);
    if (launch_log.size() == 2) begin
      chk("first_byte", launch_log[0], 8'h55);
      chk("second_byte", launch_log[1], 8'hA3);
      chk("launch_latency", launch_cyc[0] - w_cyc, 1);
      gap = launch_cyc[1] - launch_cyc[0];
      chk("second_after_busy_falls", gap > busy_len + 1, 1'b1);
    end

    // Dummy byte parks the FSM behind a held-busy core; then 17 writes.
    core_hold = 1'b1;
    busy_len = 3;
    launch_log.delete(); launch_cyc.delete();
    tick(); wr_en = 1'b1; wr_data = 8'hEE;
    repeat (6) tick();
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 15) chk("tx_full_before_16th", tx_full, 1'b0);
      if (i == 16) chk("tx_full_after_16", tx_full, 1'b1);
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
    end
    tick();
    chk("tx_count_full", tx_count, 5'd16);
    core_hold = 1'b0;
    wait_drain(800);
    repeat (3) tick();
    chk("seventeen_launches", launch_log.size(), 17);
    if (launch_log.size() == 17) begin
      chk("dummy_byte", launch_log[0], 8'hEE);
      for (int i = 0; i < 16; i++) begin
        exp_b = 8'h20 + 8'(i);
        chk("fill_sequence", launch_log[i+1], exp_b);
      end
    end

    // RX overflow: 17 receives, no reads.
    for (int i = 0; i < 17; i++) begin
      tick(); uart_received = 1'b1; uart_rx_byte = 8'(i);
    end
    tick();
    chk("rx_overflow_set", rx_overflow, 1'b1);
    chk("rx_count_16", rx_count, 5'd16);
    chk("rx_head_00", rd_data, 8'h00);
`ifdef UART_BRIDGE_OVERFLOW_CNT_EN
    chk("drop_count_1", rx_drop_count, 8'd1);
`endif
    clr_flags = 1'b1;
    tick();
    chk("rx_overflow_cleared", rx_overflow, 1'b0);
    uart_received = 1'b1; uart_rx_byte = 8'h77; rd_en = 1'b1;
    tick();
    chk("full_rx_rd_no_overflow", rx_overflow, 1'b0);
    chk("full_rx_rd_count", rx_count, 5'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 1) : 8'h77;
      chk("rx_drain_order", rd_data, exp_b);
      rd_en = 1'b1;
      tick();
    end
    chk("rx_empty_after_drain", rx_empty, 1'b1);
    rd_en = 1'b1;                 // read while empty is ignored
    tick();
    chk("rx_empty_read_ignored", rx_count, 5'd0);

    // Framing-error flag: set, clear, clear-with-set.
    uart_rx_error = 1'b1; tick();
    chk("frame_err_set", rx_frame_err, 1'b1);
    clr_flags = 1'b1; tick();
    chk("frame_err_cleared", rx_frame_err, 1'b0);
    clr_flags = 1'b1; uart_rx_error = 1'b1; tick();
    chk("frame_err_set_wins", rx_frame_err, 1'b1);
    clr_flags = 1'b1; tick();
    chk("frame_err_cleared2", rx_frame_err, 1'b0);

    // Randomized traffic on both directions.
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (i % 50 == 0) busy_len = $urandom_range(1, 6);
      wr_en = ($urandom_range(0, 99) < 30);
      wr_data = 8'($urandom);
      uart_received = ($urandom_range(0, 99) < 35);
      uart_rx_byte = 8'($urandom);
      rd_en = ($urandom_range(0, 99) < 30);
      uart_rx_error = ($urandom_range(0, 99) < 3);
      clr_flags = ($urandom_range(0, 99) < 4);
    end
    tick();
    wait_drain(400);

    // Reset while the FSM waits on a busy core with 3 bytes queued.
    busy_len = 20;
    tick(); uart_received = 1'b1; uart_rx_byte = 8'h3C; uart_rx_error = 1'b1;
    launch_log.delete(); launch_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      tick(); wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
    end
    n = 0;
    while (launch_log.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_op_launch_seen", launch_log.size(), 1);
    repeat (5) tick();
    chk("in_wait_done", tx_state, 2'd2);
    chk("three_queued", tx_count, 5'd3);
    rst_n = 1'b0;
    tick();
    check_reset_values("mid_reset");
    chk("mid_reset_tx_count", tx_count, 5'd0);
    rst_n = 1'b1;
    base = launch_log.size();
    repeat (40) tick();
    chk("no_launch_after_reset", launch_log.size(), base);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
